// File: rtl/bus_data_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : bus_data_dispatcher
// Brief    : Streams a contiguous global-buffer region onto one PE-array bus,
//            tagging every word with its destination ID, under bus_ready
//            flow control, and pulses done when the region has been sent.
// Revision : 1.0 - initial release
// ============================================================================
module bus_data_dispatcher #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ID_WIDTH-1:0]   id_base,
    input  logic [CNT_WIDTH-1:0]  num_ids,
    input  logic [CNT_WIDTH-1:0]  words_per_id,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [ID_WIDTH-1:0]   bus_id,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int c_PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int c_CW = $clog2(SKID_DEPTH + 1);
    localparam int c_TW = 2 * CNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ID_WIDTH-1:0]   r_cur_id;
    logic [CNT_WIDTH-1:0]  r_words_per_id;
    logic [CNT_WIDTH-1:0]  r_word_idx;
    logic [c_TW-1:0]       r_reads_left;
    logic                  r_inflight;
    logic [ID_WIDTH-1:0]   r_inflight_id;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_fifo_data [SKID_DEPTH];
    logic [ID_WIDTH-1:0]   r_fifo_id   [SKID_DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic [c_CW-1:0]       w_count_next;

    logic                  w_start_ok;
    logic                  w_cfg_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;
    logic                  w_credit;
    logic                  w_last_read;
    logic [c_TW-1:0]       w_total;
    logic [c_CW:0]         w_occ;
    logic [c_CW:0]         w_limit;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(SKID_DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    assign w_total     = c_TW'(num_ids) * c_TW'(words_per_id);
    assign w_cfg_empty = (num_ids == '0) || (words_per_id == '0);
    assign w_pop       = bus_valid & bus_ready;
    assign w_push      = r_inflight;
    assign w_last_read = (r_reads_left == c_TW'(1));

    // Credit: buffered + in-flight words minus this cycle's pop must leave room.
    assign w_occ    = {1'b0, r_count} + {{c_CW{1'b0}}, r_inflight};
    assign w_limit  = (c_CW + 1)'(SKID_DEPTH) + {{c_CW{1'b0}}, w_pop};
    assign w_credit = (w_occ < w_limit);

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_start_ok   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    if (w_cfg_empty) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_credit) begin
                    w_rd_en = 1'b1;
                    if (w_last_read) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((r_count == '0) && !r_inflight) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CW'(1);
            2'b01:   w_count_next = r_count - c_CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_cur_id       <= '0;
            r_words_per_id <= '0;
            r_word_idx     <= '0;
            r_reads_left   <= '0;
            r_inflight     <= 1'b0;
            r_inflight_id  <= '0;
            r_done         <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            r_count    <= w_count_next;
            // Look ahead so done is a flop that rises right after the last handshake.
            r_done     <= (w_state_next == ST_DRAIN) && (w_count_next == '0) && !w_rd_en;

            if (w_start_ok) begin
                r_addr         <= base_addr;
                r_cur_id       <= id_base;
                r_words_per_id <= words_per_id;
                r_word_idx     <= '0;
                r_reads_left   <= w_total;
            end else if (w_rd_en) begin
                r_addr        <= r_addr + ADDR_WIDTH'(1);
                r_reads_left  <= r_reads_left - c_TW'(1);
                r_inflight_id <= r_cur_id;
                if (r_word_idx == r_words_per_id - CNT_WIDTH'(1)) begin
                    r_word_idx <= '0;
                    r_cur_id   <= r_cur_id + ID_WIDTH'(1);
                end else begin
                    r_word_idx <= r_word_idx + CNT_WIDTH'(1);
                end
            end

            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Storage needs no reset: bus_valid masks the contents while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rd_data;
            r_fifo_id[r_wr_ptr]   <= r_inflight_id;
        end
    end

    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = r_addr;
    assign bus_valid   = (r_count != '0);
    assign bus_data    = bus_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus_id      = bus_valid ? r_fifo_id[r_rd_ptr] : '0;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: doc/bus_data_dispatcher.md
Name: bus_data_dispatcher

Overview:
- Upstream feeder for one PE-array input bus (weight, ifmap or psum_in).
- Reads a contiguous region of a global-buffer bank (1-cycle synchronous read) and broadcasts each word on the bus with a destination ID, so each PE router picks up the words tagged for it.
- Transfers are flow-controlled by bus_ready, which is the AND of the load_ready flags of the target PE column.
- Signals done when the whole region has been transferred.

Parameters:
DATA_WIDTH, 16, bus and buffer word width
ADDR_WIDTH, 8, buffer address width
ID_WIDTH, 8, destination ID width
CNT_WIDTH, 8, width of the num_ids and words_per_id counters
SKID_DEPTH, 2, output buffer entries; minimum 2, which is what allows full throughput with 1-cycle read latency

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that launches a transfer
base_addr  in  ADDR_WIDTH  first buffer address, sampled on start
id_base  in  ID_WIDTH  ID of the first destination group, sampled on start
num_ids  in  CNT_WIDTH  number of destination IDs, sampled on start
words_per_id  in  CNT_WIDTH  number of words sent per ID, sampled on start
mem_rd_en  out  1  buffer read enable
mem_rd_addr  out  ADDR_WIDTH  buffer read address
mem_rd_data  in  DATA_WIDTH  buffer read data, valid 1 cycle after mem_rd_en
bus_data  out  DATA_WIDTH  bus word
bus_id  out  ID_WIDTH  destination ID of bus_data
bus_valid  out  1  bus word valid
bus_ready  in  1  column can accept a word
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset: synchronous, active-high, highest priority, may occur mid-transfer. On the next edge the FSM returns to IDLE; counters, skid buffer and in-flight flag clear. bus_valid, mem_rd_en, busy and done go to 0; bus_data, bus_id and mem_rd_addr go to 0. An in-flight read result arriving after reset is discarded.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - On start, latch all configuration inputs and set busy on the next edge.
  - If num_ids==0 or words_per_id==0, go directly to DRAIN. done pulses 1 cycle after start with no reads and no bus traffic.
  - Otherwise go to RUN.
- RUN:
  - Issue one read per cycle when (skid_count + inflight − pop) < SKID_DEPTH, where pop = bus_valid & bus_ready.
  - Address starts at base_addr and increments by 1 per read, wrapping modulo 2^ADDR_WIDTH.
  - Each read is tagged with id_base + id_idx, wrapping modulo 2^ID_WIDTH.
  - word_idx counts 0..words_per_id−1. On wrap it returns to 0 and id_idx increments.
  - After read number num_ids*words_per_id has issued, go to DRAIN.
- DRAIN:
  - When the skid buffer is empty, no read is in flight and no pop occurs that cycle, pulse done for 1 cycle, drop busy and return to IDLE.
  - done is registered: it is high in the cycle after the last transfer handshake.
- Skid buffer: FIFO holding {id, data} pairs.
  - Write on the cycle after mem_rd_en.
  - Head drives bus_data and bus_id; bus_valid = !empty.
  - A simultaneous push and pop is legal and leaves the count unchanged.
  - The FIFO never overflows, guaranteed by the credit rule above.
- Handshake rules:
  - A word transfers on a rising edge where bus_valid & bus_ready.
  - While bus_valid=1 and bus_ready=0, bus_data and bus_id hold stable.
  - bus_valid never drops without a transfer, except on reset.
- Latency: start sampled at edge E0 → mem_rd_en high in cycle after E0 → data captured at E2 → bus_valid high after E2. First word is visible 2 cycles after the start edge.
- Throughput: with bus_ready held at 1, one word per cycle sustained, no bubbles.
- start while busy=1 is ignored and latched configuration is unchanged.
- bus_ready toggling has no effect on read ordering. Words are emitted in address order, IDs non-decreasing modulo wrap.
- Width rules: total word count = num_ids*words_per_id, computed in 2*CNT_WIDTH bits. A transfer longer than 2^ADDR_WIDTH words re-reads wrapped addresses. This is legal and not flagged.

Test Plan:
1. base_addr=0x10, id_base=3, num_ids=2, words_per_id=3, bus_ready=1, buffer[i]=i → bus emits data 0x10..0x15 with ids 3,3,3,4,4,4 on 6 consecutive cycles starting 2 cycles after start; done 1 cycle after last word; busy high throughout.
2. Same config, bus_ready=0 for 5 cycles after the first bus_valid → bus_data=0x10/id 3 held stable; mem_rd_en issues at most 2 reads then stops; after release, all 6 words arrive in order with none lost or duplicated.
3. bus_ready alternating 1/0 each cycle, num_ids=1, words_per_id=8 → exactly 8 transfers, in order, and done after the 8th.
4. num_ids=0, words_per_id=5 → no mem_rd_en, no bus_valid; done pulses exactly 1 cycle after start; start pulse during a running transfer → ignored, word count unchanged.
5. base_addr=0xFE, id_base=0xFF, num_ids=2, words_per_id=2 → addresses 0xFE,0xFF,0x00,0x01; ids 0xFF,0xFF,0x00,0x00.
6. rst asserted while 2 words are buffered and 1 read is in flight, bus_ready=0 → next cycle bus_valid=0, busy=0, done=0; a new start then runs case 1 correctly with no stale words.
